morse_decoder: RTL and testbench



---
 rtl/morse_decoder.sv | 166 ++++++++++++++++
 tb/tb_morse_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - Morse receiver: times key marks/spaces, decodes ITU digits and letters.
module morse_decoder #(
    parameter int CNT_W    = 24,
    parameter int DOT_MAX  = 12500000,
    parameter int CHAR_GAP = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    output logic [5:0] num,
    output logic       ready,
    output logic       error,
    output logic [4:0] ponto,
    output logic [4:0] traco
);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_DECODE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DOT_MAX_C = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CHAR_GAP - 1);

    state_t           state_q;
    logic             key_meta_q, key_s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       len_q;
    logic [4:0]       dot_q, dash_q;
    logic             ovf_q;
    logic [5:0]       num_q;
    logic             ready_q, error_q;
    logic [4:0]       ponto_q, traco_q;

    logic [CNT_W-1:0] cnt_sat;
    logic [4:0]       elem_mask;
    logic             is_dot;
    logic [6:0]       lut;

    // Elements are stored left-aligned; the dash mask plus length identifies a symbol.
    function automatic logic [6:0] lookup(input logic [2:0] len, input logic [4:0] dash);
        case ({len, dash})
            8'b001_00000: lookup = {1'b1, 6'd14};
            8'b001_10000: lookup = {1'b1, 6'd29};
            8'b010_00000: lookup = {1'b1, 6'd18};
            8'b010_01000: lookup = {1'b1, 6'd10};
            8'b010_10000: lookup = {1'b1, 6'd23};
            8'b010_11000: lookup = {1'b1, 6'd22};
            8'b011_00000: lookup = {1'b1, 6'd28};
            8'b011_00100: lookup = {1'b1, 6'd30};
            8'b011_01000: lookup = {1'b1, 6'd27};
            8'b011_01100: lookup = {1'b1, 6'd32};
            8'b011_10000: lookup = {1'b1, 6'd13};
            8'b011_10100: lookup = {1'b1, 6'd20};
            8'b011_11000: lookup = {1'b1, 6'd16};
            8'b011_11100: lookup = {1'b1, 6'd24};
            8'b100_00000: lookup = {1'b1, 6'd17};
            8'b100_00010: lookup = {1'b1, 6'd31};
            8'b100_00100: lookup = {1'b1, 6'd15};
            8'b100_01000: lookup = {1'b1, 6'd21};
            8'b100_01100: lookup = {1'b1, 6'd25};
            8'b100_01110: lookup = {1'b1, 6'd19};
            8'b100_10000: lookup = {1'b1, 6'd11};
            8'b100_10010: lookup = {1'b1, 6'd33};
            8'b100_10100: lookup = {1'b1, 6'd12};
            8'b100_10110: lookup = {1'b1, 6'd34};
            8'b100_11000: lookup = {1'b1, 6'd35};
            8'b100_11010: lookup = {1'b1, 6'd26};
            8'b101_11111: lookup = {1'b1, 6'd0};
            8'b101_01111: lookup = {1'b1, 6'd1};
            8'b101_00111: lookup = {1'b1, 6'd2};
            8'b101_00011: lookup = {1'b1, 6'd3};
            8'b101_00001: lookup = {1'b1, 6'd4};
            8'b101_00000: lookup = {1'b1, 6'd5};
            8'b101_10000: lookup = {1'b1, 6'd6};
            8'b101_11000: lookup = {1'b1, 6'd7};
            8'b101_11100: lookup = {1'b1, 6'd8};
            8'b101_11110: lookup = {1'b1, 6'd9};
            default:      lookup = {1'b0, 6'd63};
        endcase
    endfunction

    assign cnt_sat   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
    assign elem_mask = 5'b10000 >> len_q;
    assign is_dot    = (cnt_q <= DOT_MAX_C);
    assign lut       = lookup(len_q, dash_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
            dot_q      <= '0;
            dash_q     <= '0;
            ovf_q      <= 1'b0;
            num_q      <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            ponto_q    <= '0;
            traco_q    <= '0;
        end else begin
            key_meta_q <= key;
            key_s_q    <= key_meta_q;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (key_s_q) begin
                        state_q <= S_MARK;
                        cnt_q   <= CNT_ONE;
                    end
                end
                S_MARK: begin
                    if (key_s_q) begin
                        cnt_q <= cnt_sat;
                    end else begin
                        // A sixth element only flags overflow; the captured pattern stays as-is.
                        if (len_q < 3'd5) begin
                            if (is_dot) dot_q  <= dot_q | elem_mask;
                            else        dash_q <= dash_q | elem_mask;
                            len_q <= len_q + 3'd1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                        state_q <= S_SPACE;
                        cnt_q   <= CNT_ONE;
                    end
                end
                S_SPACE: begin
                    if (key_s_q) begin
                        state_q <= S_MARK;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q <= cnt_sat;
                        if (cnt_q >= GAP_LAST) state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (lut[6] && !ovf_q) begin
                        num_q   <= lut[5:0];
                        ready_q <= 1'b1;
                    end else begin
                        num_q   <= 6'd63;
                        error_q <= 1'b1;
                    end
                    ponto_q <= dot_q;
                    traco_q <= dash_q;
                    dot_q   <= '0;
                    dash_q  <= '0;
                    len_q   <= '0;
                    ovf_q   <= 1'b0;
                    cnt_q   <= CNT_ONE;
                    state_q <= key_s_q ? S_MARK : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign num   = num_q;
    assign ready = ready_q;
    assign error = error_q;
    assign ponto = ponto_q;
    assign traco = traco_q;

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - randomized self-checking bench for morse_decoder.
module tb_morse_decoder;
    localparam int CNT_W    = 8;
    localparam int DOT_MAX  = 3;
    localparam int CHAR_GAP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       key;
    logic [5:0] num;
    logic       ready, error;
    logic [4:0] ponto, traco;

    morse_decoder #(.CNT_W(CNT_W), .DOT_MAX(DOT_MAX), .CHAR_GAP(CHAR_GAP)) dut (
        .clk(clk), .reset(reset), .key(key), .num(num), .ready(ready),
        .error(error), .ponto(ponto), .traco(traco)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         num;
        logic [4:0] p;
        logic [4:0] t;
        bit         err;
        int         lat;
    } ev_t;

    ev_t  evq[$];
    ev_t  mon_e;
    int   cycle = 0;
    int   last_fall = 0;
    int   both_cnt = 0;
    int   checks = 0;
    int   passes = 0;

    string tbl[36] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                       "---..", "----.", ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                       "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (ready || error) begin
            mon_e.num = num;
            mon_e.p   = ponto;
            mon_e.t   = traco;
            mon_e.err = error;
            mon_e.lat = cycle - last_fall;
            evq.push_back(mon_e);
            if (ready && error) both_cnt++;
        end
    end

    function automatic void model(input string pat, output int en, output logic [4:0] ep,
                                  output logic [4:0] et, output bit eerr);
        int idx = -1;
        for (int k = 0; k < 36; k++) if (tbl[k] == pat) idx = k;
        ep = '0;
        et = '0;
        for (int i = 0; i < pat.len() && i < 5; i++) begin
            if (pat[i] == "-") et[4-i] = 1'b1;
            else               ep[4-i] = 1'b1;
        end
        if (pat.len() > 5 || idx < 0) begin
            en = 63; eerr = 1'b1;
        end else begin
            en = idx; eerr = 1'b0;
        end
    endfunction

    task automatic drive(input logic lv, input int n);
        key = lv;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input string pat, input int gap, input int end_gap);
        for (int i = 0; i < pat.len(); i++) begin
            if (pat[i] == "-") drive(1'b1, $urandom_range(DOT_MAX + 5, DOT_MAX + 1));
            else               drive(1'b1, $urandom_range(DOT_MAX, 1));
            last_fall = cycle;
            if (i < pat.len() - 1) drive(1'b0, (gap > 0) ? gap : $urandom_range(CHAR_GAP - 1, 1));
        end
        drive(1'b0, end_gap);
    endtask

    task automatic expect_char(input string pat, input bit chk_lat);
        int         en;
        logic [4:0] ep, et;
        bit         eerr;
        int         w = 0;
        ev_t        e;
        model(pat, en, ep, et, eerr);
        while (evq.size() == 0 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (evq.size() == 0) begin
            $display("FAIL timeout '%s': no ready/error pulse, required one", pat);
            return;
        end
        passes++;
        e = evq.pop_front();
        checks++;
        if (e.num !== en) $display("FAIL num '%s': got %0d, required %0d", pat, e.num, en);
        else passes++;
        checks++;
        if (e.err !== eerr) $display("FAIL error '%s': got %0d, required %0d", pat, e.err, eerr);
        else passes++;
        checks++;
        if (e.p !== ep || e.t !== et)
            $display("FAIL pattern '%s': got ponto=%b traco=%b, required ponto=%b traco=%b",
                     pat, e.p, e.t, ep, et);
        else passes++;
        if (chk_lat) begin
            checks++;
            if (e.lat < CHAR_GAP + 2 || e.lat > CHAR_GAP + 4)
                $display("FAIL latency '%s': got %0d, required %0d..%0d", pat, e.lat,
                         CHAR_GAP + 2, CHAR_GAP + 4);
            else passes++;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (num !== 6'd0 || ready !== 1'b0 || error !== 1'b0 || ponto !== 5'd0 || traco !== 5'd0)
            $display("FAIL %s: got num=%0d ready=%b error=%b ponto=%b traco=%b, required all 0",
                     name, num, ready, error, ponto, traco);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_values");
        reset = 1'b0;
        drive(1'b0, 3);
    endtask

    task automatic test_letter_a();
        drive(1'b1, 2); drive(1'b0, 2); drive(1'b1, 6);
        last_fall = cycle;
        drive(1'b0, 10);
        expect_char(".-", 1'b1);
    endtask

    task automatic test_digit_zero();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5);
            last_fall = cycle;
            drive(1'b0, (i < 4) ? 2 : 10);
        end
        expect_char("-----", 1'b1);
    endtask

    task automatic test_dot_boundary();
        drive(1'b1, 1); last_fall = cycle; drive(1'b0, 10);
        expect_char(".", 1'b1);
        drive(1'b1, DOT_MAX); last_fall = cycle; drive(1'b0, 10);
        expect_char(".", 1'b1);
        drive(1'b1, DOT_MAX + 1); last_fall = cycle; drive(1'b0, 10);
        expect_char("-", 1'b1);
    endtask

    task automatic test_overflow();
        send("......", 0, CHAR_GAP + 2);
        expect_char("......", 1'b1);
        send(".", 0, CHAR_GAP + 2);
        expect_char(".", 1'b1);
    endtask

    task automatic test_invalid_and_gap();
        send("..--", 0, CHAR_GAP + 2);
        expect_char("..--", 1'b1);
        send("..", CHAR_GAP - 1, CHAR_GAP + 2);
        expect_char("..", 1'b1);
    endtask

    task automatic test_held_key();
        drive(1'b1, 400);
        last_fall = cycle;
        checks++;
        if (evq.size() != 0) $display("FAIL held_key: got %0d pulses, required 0", evq.size());
        else passes++;
        drive(1'b0, CHAR_GAP + 4);
        expect_char("-", 1'b1);
    endtask

    task automatic test_back_to_back();
        int a = $urandom_range(35, 0);
        int b = $urandom_range(35, 0);
        send(tbl[a], 0, CHAR_GAP);
        send(tbl[b], 0, CHAR_GAP + 3);
        expect_char(tbl[a], 1'b0);
        expect_char(tbl[b], 1'b1);
    endtask

    task automatic test_reset_mid_char();
        drive(1'b1, 2); drive(1'b0, 2); drive(1'b1, 1);
        reset = 1'b1;
        #2;
        check_idle_outputs("reset_async");
        key = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 12);
        checks++;
        if (evq.size() != 0) $display("FAIL reset_residue: got %0d pulses, required 0", evq.size());
        else passes++;
        evq.delete();
        send(".....", 0, CHAR_GAP + 2);
        expect_char(".....", 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            string s = "";
            if ($urandom_range(9, 0) < 7) begin
                s = tbl[$urandom_range(35, 0)];
            end else begin
                int l = $urandom_range(7, 1);
                for (int i = 0; i < l; i++) begin
                    if ($urandom_range(1, 0) == 1) s = {s, "-"};
                    else                            s = {s, "."};
                end
            end
            send(s, 0, $urandom_range(CHAR_GAP + 5, CHAR_GAP + 2));
            expect_char(s, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b0;
        key   = 1'b0;
        #1;
        test_reset();
        test_letter_a();
        test_digit_zero();
        test_dot_boundary();
        test_overflow();
        test_invalid_and_gap();
        test_held_key();
        test_back_to_back();
        test_reset_mid_char();
        test_random();
        drive(1'b0, 20);
        checks++;
        if (both_cnt !== 0) $display("FAIL exclusive: got %0d cycles with ready and error, required 0", both_cnt);
        else passes++;
        checks++;
        if (evq.size() != 0) $display("FAIL spurious: got %0d unexpected pulses, required 0", evq.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
